// File: rtl/sdram_arbiter_if.sv
// Bundle of client request/grant signals and SDRAM controller signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface sdram_arbiter_if #(
    parameter int HADDR_WIDTH = 24,
    parameter int HDATA_WIDTH = 16
);
    logic                   rd_req;
    logic [HADDR_WIDTH-1:0] rd_addr;
    logic                   rd_gnt;
    logic                   rd_valid;
    logic [HDATA_WIDTH-1:0] rd_data;
    logic                   wr_req;
    logic [HADDR_WIDTH-1:0] wr_addr;
    logic [HDATA_WIDTH-1:0] wr_data;
    logic                   wr_gnt;
    logic                   wr_done;
    logic                   arb_busy;
    logic [HADDR_WIDTH-1:0] sd_rd_addr;
    logic                   sd_rd_enable;
    logic [HDATA_WIDTH-1:0] sd_rd_data;
    logic                   sd_rd_ready;
    logic [HADDR_WIDTH-1:0] sd_wr_addr;
    logic [HDATA_WIDTH-1:0] sd_wr_data;
    logic                   sd_wr_enable;
    logic                   sd_busy;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sd_rd_data, sd_rd_ready, sd_busy,
        output rd_gnt, rd_valid, rd_data, wr_gnt, wr_done, arb_busy,
               sd_rd_addr, sd_rd_enable, sd_wr_addr, sd_wr_data, sd_wr_enable
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, sd_rd_data, sd_rd_ready, sd_busy,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, wr_done, arb_busy,
               sd_rd_addr, sd_rd_enable, sd_wr_addr, sd_wr_data, sd_wr_enable
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares a single-port SDRAM controller between the LCD scanout reader (priority) and a
// framebuffer writer; one operation in flight, bounded read streak keeps the writer alive.
//
//   state | meaning
//   IDLE  | no operation; grant when controller not busy
//   ISSUE | one enable held until the controller raises busy
//   RUN   | controller executing; wait for busy to fall (capture read data on rd_ready)
module sdram_arbiter #(
    parameter int HADDR_WIDTH   = 24,
    parameter int HDATA_WIDTH   = 16,
    parameter int RD_STREAK_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sdram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

    localparam logic [7:0] STREAK_MAX = 8'(RD_STREAK_MAX);

    state_t                 r_state, w_state;
    logic                   r_op_wr, w_op_wr;
    logic [7:0]             r_streak, w_streak;
    logic                   r_rd_gnt, w_rd_gnt;
    logic                   r_wr_gnt, w_wr_gnt;
    logic                   r_rd_valid, w_rd_valid;
    logic                   r_wr_done, w_wr_done;
    logic                   r_busy, w_busy;
    logic                   r_sd_rd_en, w_sd_rd_en;
    logic                   r_sd_wr_en, w_sd_wr_en;
    logic [HDATA_WIDTH-1:0] r_rd_data, w_rd_data;
    logic [HADDR_WIDTH-1:0] r_sd_rd_addr, w_sd_rd_addr;
    logic [HADDR_WIDTH-1:0] r_sd_wr_addr, w_sd_wr_addr;
    logic [HDATA_WIDTH-1:0] r_sd_wr_data, w_sd_wr_data;
    logic                   w_pick_rd, w_pick_wr;

    always_comb begin
        w_state      = r_state;
        w_op_wr      = r_op_wr;
        w_streak     = r_streak;
        w_rd_gnt     = 1'b0;
        w_wr_gnt     = 1'b0;
        w_rd_valid   = 1'b0;
        w_wr_done    = 1'b0;
        w_sd_rd_en   = r_sd_rd_en;
        w_sd_wr_en   = r_sd_wr_en;
        w_rd_data    = r_rd_data;
        w_sd_rd_addr = r_sd_rd_addr;
        w_sd_wr_addr = r_sd_wr_addr;
        w_sd_wr_data = r_sd_wr_data;
        w_pick_rd    = 1'b0;
        w_pick_wr    = 1'b0;

        case (r_state)
            IDLE: begin
                if (!bus.sd_busy) begin
                    // Reads win unless the writer has waited through a full streak.
                    if (bus.rd_req && (!bus.wr_req || r_streak != STREAK_MAX))
                        w_pick_rd = 1'b1;
                    else if (bus.wr_req)
                        w_pick_wr = 1'b1;
                end
                if (w_pick_rd) begin
                    w_state      = ISSUE;
                    w_op_wr      = 1'b0;
                    w_rd_gnt     = 1'b1;
                    w_sd_rd_en   = 1'b1;
                    w_sd_rd_addr = bus.rd_addr;
                    if (!bus.wr_req)
                        w_streak = 8'd0;
                    else if (r_streak != STREAK_MAX)
                        w_streak = r_streak + 8'd1;
                end else if (w_pick_wr) begin
                    w_state      = ISSUE;
                    w_op_wr      = 1'b1;
                    w_wr_gnt     = 1'b1;
                    w_sd_wr_en   = 1'b1;
                    w_sd_wr_addr = bus.wr_addr;
                    w_sd_wr_data = bus.wr_data;
                    w_streak     = 8'd0;
                end
            end
            ISSUE: begin
                // A refreshing controller ignores enable, so hold it until busy shows acceptance.
                if (bus.sd_busy) begin
                    w_sd_rd_en = 1'b0;
                    w_sd_wr_en = 1'b0;
                    w_state    = RUN;
                end
            end
            RUN: begin
                if (!r_op_wr && bus.sd_rd_ready) begin
                    w_rd_data  = bus.sd_rd_data;
                    w_rd_valid = 1'b1;
                end
                if (!bus.sd_busy) begin
                    w_state   = IDLE;
                    w_wr_done = r_op_wr;
                end
            end
            default: begin
                w_state    = IDLE;
                w_sd_rd_en = 1'b0;
                w_sd_wr_en = 1'b0;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op_wr      <= 1'b0;
            r_streak     <= 8'd0;
            r_rd_gnt     <= 1'b0;
            r_wr_gnt     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_wr_done    <= 1'b0;
            r_busy       <= 1'b0;
            r_sd_rd_en   <= 1'b0;
            r_sd_wr_en   <= 1'b0;
            r_rd_data    <= '0;
            r_sd_rd_addr <= '0;
            r_sd_wr_addr <= '0;
            r_sd_wr_data <= '0;
        end else begin
            r_state      <= w_state;
            r_op_wr      <= w_op_wr;
            r_streak     <= w_streak;
            r_rd_gnt     <= w_rd_gnt;
            r_wr_gnt     <= w_wr_gnt;
            r_rd_valid   <= w_rd_valid;
            r_wr_done    <= w_wr_done;
            r_busy       <= w_busy;
            r_sd_rd_en   <= w_sd_rd_en;
            r_sd_wr_en   <= w_sd_wr_en;
            r_rd_data    <= w_rd_data;
            r_sd_rd_addr <= w_sd_rd_addr;
            r_sd_wr_addr <= w_sd_wr_addr;
            r_sd_wr_data <= w_sd_wr_data;
        end
    end

    assign bus.rd_gnt       = r_rd_gnt;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_data      = r_rd_data;
    assign bus.wr_gnt       = r_wr_gnt;
    assign bus.wr_done      = r_wr_done;
    assign bus.arb_busy     = r_busy;
    assign bus.sd_rd_addr   = r_sd_rd_addr;
    assign bus.sd_rd_enable = r_sd_rd_en;
    assign bus.sd_wr_addr   = r_sd_wr_addr;
    assign bus.sd_wr_data   = r_sd_wr_data;
    assign bus.sd_wr_enable = r_sd_wr_en;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller model plus scenario tasks.
// Expected read data is queued at request time and compared when rd_valid appears.
module tb_sdram_arbiter;
    localparam int REFRESH_CYCLES = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.HADDR_WIDTH(24), .HDATA_WIDTH(16)) bus ();

    sdram_arbiter #(.HADDR_WIDTH(24), .HDATA_WIDTH(16), .RD_STREAK_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Controller model: accepts an enable when idle and not refreshing, busy follows a cycle later.
    logic        m_busy, m_rdy, m_is_rd;
    logic [15:0] m_rdata;
    logic [11:0] m_addr;
    int          m_cnt, m_refresh;
    int          m_accepts = 0;
    int          m_both = 0;
    int          m_refresh_taken = 0;
    int          refresh_req = 0;
    logic [15:0] mem [0:4095];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_rdy     <= 1'b0;
            m_is_rd   <= 1'b0;
            m_rdata   <= 16'h0;
            m_addr    <= 12'h0;
            m_cnt     <= 0;
            m_refresh <= 0;
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h1000 + 16'(i);
            mem[12'h123] <= 16'hBEEF;
        end else begin
            m_rdy <= 1'b0;
            if (bus.sd_rd_enable && bus.sd_wr_enable) m_both <= m_both + 1;
            if (m_refresh > 0) m_refresh <= m_refresh - 1;
            if (m_cnt > 0) begin
                m_cnt  <= m_cnt - 1;
                m_busy <= (m_cnt > 1);
                if (m_cnt == 2 && m_is_rd) begin
                    m_rdy   <= 1'b1;
                    m_rdata <= mem[m_addr];
                end
            end else if ((bus.sd_rd_enable || bus.sd_wr_enable) && m_refresh == 0) begin
                if (refresh_req != m_refresh_taken) begin
                    m_refresh       <= REFRESH_CYCLES;
                    m_refresh_taken <= m_refresh_taken + 1;
                end else begin
                    m_accepts <= m_accepts + 1;
                    m_is_rd   <= bus.sd_rd_enable;
                    if (bus.sd_rd_enable) begin
                        m_cnt  <= 8;
                        m_addr <= bus.sd_rd_addr[11:0];
                    end else begin
                        m_cnt  <= 4;
                        mem[bus.sd_wr_addr[11:0]] <= bus.sd_wr_data;
                    end
                end
            end
        end
    end

    assign bus.sd_busy     = m_busy;
    assign bus.sd_rd_ready = m_rdy;
    assign bus.sd_rd_data  = m_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q [$];
    logic [15:0] ref_mem [0:4095];

    function automatic logic [86:0] outs();
        return {bus.rd_gnt, bus.rd_valid, bus.rd_data, bus.wr_gnt, bus.wr_done, bus.arb_busy,
                bus.sd_rd_addr, bus.sd_rd_enable, bus.sd_wr_addr, bus.sd_wr_data, bus.sd_wr_enable};
    endfunction

    task automatic do_read(input logic [23:0] addr, output int lat);
        exp_q.push_back(ref_mem[addr[11:0]]);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rd_gnt) begin lat = i; break; end
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [15:0] data, output int lat);
        ref_mem[addr[11:0]] = data;
        bus.wr_req  = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.wr_gnt) begin lat = i; break; end
        end
        bus.wr_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (outs() !== 87'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", outs());
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (outs() !== 87'd0) begin
            miscompares++;
            $display("FAIL idle_outputs: got %h want 0", outs());
        end
    endtask

    task automatic test_single_read();
        int lat; bit found; logic prev_rdy; logic [15:0] exp;
        do_read(24'h000123, lat);
        vectors++;
        if (lat < 0) begin miscompares++; $display("FAIL rd_gnt_timeout: got none want pulse"); end
        vectors++;
        if ({bus.sd_rd_enable, bus.sd_wr_enable, bus.sd_rd_addr} !== {1'b1, 1'b0, 24'h000123}) begin
            miscompares++;
            $display("FAIL rd_issue: got en=%b/%b addr=%h want 1/0 000123",
                     bus.sd_rd_enable, bus.sd_wr_enable, bus.sd_rd_addr);
        end
        @(negedge clk);
        vectors++;
        if (bus.rd_gnt !== 1'b0) begin miscompares++; $display("FAIL rd_gnt_width: got %b want 0", bus.rd_gnt); end
        found = 0; prev_rdy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rd_valid) begin found = 1; break; end
            prev_rdy = bus.sd_rd_ready;
            @(negedge clk);
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL rd_valid_timeout: got none want pulse"); end
        vectors++;
        if (prev_rdy !== 1'b1) begin miscompares++; $display("FAIL rd_valid_latency: rd_ready prev cycle got %b want 1", prev_rdy); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        vectors++;
        if (bus.rd_data !== exp || exp !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rd_data: got %h want %h", bus.rd_data, 16'hBEEF);
        end
        @(negedge clk);
        vectors++;
        if ({bus.rd_valid, bus.rd_data, bus.arb_busy} !== {1'b0, 16'hBEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_after: got valid=%b data=%h busy=%b want 0 beef 0", bus.rd_valid, bus.rd_data, bus.arb_busy);
        end
    endtask

    task automatic test_single_write();
        int lat, a0; bit found;
        a0 = m_accepts;
        do_write(24'h0A0010, 16'h5A5A, lat);
        vectors++;
        if (lat < 0 || {bus.sd_wr_enable, bus.sd_rd_enable} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_issue: got lat=%0d en=%b/%b want gnt and wr enable only", lat, bus.sd_wr_enable, bus.sd_rd_enable);
        end
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.wr_done) begin found = 1; break; end
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL wr_done_timeout: got none want pulse"); end
        @(negedge clk);
        vectors++;
        if (bus.wr_done !== 1'b0) begin miscompares++; $display("FAIL wr_done_width: got %b want 0", bus.wr_done); end
        vectors++;
        if (m_accepts - a0 != 1) begin miscompares++; $display("FAIL wr_accepts: got %0d want 1", m_accepts - a0); end
        vectors++;
        if (mem[12'h010] !== ref_mem[12'h010] || ref_mem[12'h010] !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL wr_mem: got %h want 5a5a", mem[12'h010]);
        end
    endtask

    task automatic test_fairness();
        bit seq [$]; int ri, wi, a0, nvalid; logic [15:0] exp;
        a0 = m_accepts; ri = 0; wi = 0; nvalid = 0;
        bus.rd_addr = 24'h000100; bus.wr_addr = 24'h000200; bus.wr_data = 16'hC000;
        bus.rd_req = 1'b1; bus.wr_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.rd_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                nvalid++;
                vectors++;
                if (bus.rd_data !== exp) begin miscompares++; $display("FAIL fair_rd_data: got %h want %h", bus.rd_data, exp); end
            end
            if (bus.rd_gnt && seq.size() < 18) begin
                exp_q.push_back(ref_mem[bus.rd_addr[11:0]]);
                seq.push_back(1'b0);
                ri++;
                bus.rd_addr = 24'h000100 + 24'(ri);
            end
            if (bus.wr_gnt && seq.size() < 18) begin
                ref_mem[bus.wr_addr[11:0]] = bus.wr_data;
                seq.push_back(1'b1);
                wi++;
                bus.wr_addr = 24'h000200 + 24'(wi);
                bus.wr_data = 16'hC000 + 16'(wi);
            end
            if (seq.size() >= 18) begin bus.rd_req = 1'b0; bus.wr_req = 1'b0; end
            if (seq.size() >= 18 && exp_q.size() == 0 && !bus.arb_busy) break;
        end
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        vectors++;
        if (seq.size() != 18) begin miscompares++; $display("FAIL fair_grants: got %0d want 18", seq.size()); end
        for (int k = 0; k < seq.size(); k++) begin
            vectors++;
            if (seq[k] !== (k % 9 == 8)) begin
                miscompares++;
                $display("FAIL fair_order[%0d]: got wr=%b want wr=%b", k, seq[k], (k % 9 == 8));
            end
        end
        vectors++;
        if (m_accepts - a0 != 18 || nvalid != 16 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL fair_count: got accepts=%0d valids=%0d pending=%0d want 18 16 0", m_accepts - a0, nvalid, exp_q.size());
        end
        vectors++;
        if (mem[12'h201] !== 16'hC001) begin miscompares++; $display("FAIL fair_wr_mem: got %h want c001", mem[12'h201]); end
    endtask

    task automatic test_refresh();
        int lat, a0, en_cycles; bit found;
        a0 = m_accepts;
        refresh_req++;
        do_write(24'h0A0020, 16'h7777, lat);
        en_cycles = 0; found = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.sd_wr_enable) en_cycles++;
            if (bus.wr_done) begin found = 1; break; end
            @(negedge clk);
        end
        vectors++;
        if (lat < 0 || !found) begin miscompares++; $display("FAIL refresh_timeout: got lat=%0d done=%b want gnt and done", lat, found); end
        vectors++;
        if (en_cycles < REFRESH_CYCLES) begin miscompares++; $display("FAIL refresh_hold: got %0d enable cycles want >= %0d", en_cycles, REFRESH_CYCLES); end
        vectors++;
        if (m_accepts - a0 != 1 || m_refresh_taken != refresh_req || mem[12'h020] !== 16'h7777) begin
            miscompares++;
            $display("FAIL refresh_once: got accepts=%0d mem=%h want 1 7777", m_accepts - a0, mem[12'h020]);
        end
    endtask

    task automatic test_back_to_back();
        int a0; bit done_seen, valid_seen, done_first; logic [15:0] exp;
        a0 = m_accepts; done_seen = 0; valid_seen = 0; done_first = 0;
        ref_mem[12'h030] = 16'h1111;
        bus.wr_req = 1'b1; bus.wr_addr = 24'h0A0030; bus.wr_data = 16'h1111;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.wr_gnt) begin
                bus.wr_req  = 1'b0;
                exp_q.push_back(ref_mem[12'h030]);
                bus.rd_req  = 1'b1;
                bus.rd_addr = 24'h0A0030;
            end
            if (bus.rd_gnt) bus.rd_req = 1'b0;
            if (bus.wr_done) done_seen = 1;
            if (bus.rd_valid) begin
                valid_seen = 1;
                done_first = done_seen;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                vectors++;
                if (bus.rd_data !== exp) begin miscompares++; $display("FAIL b2b_rd_data: got %h want %h", bus.rd_data, exp); end
                break;
            end
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        vectors++;
        if (!valid_seen || !done_first || m_accepts - a0 != 2) begin
            miscompares++;
            $display("FAIL b2b_order: got valid=%b done_first=%b accepts=%0d want 1 1 2", valid_seen, done_first, m_accepts - a0);
        end
    endtask

    task automatic test_reset_mid();
        int lat, pulses; bit in_run;
        do_read(24'h000123, lat);
        in_run = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.arb_busy && !bus.sd_rd_enable && bus.sd_busy) begin in_run = 1; break; end
        end
        @(negedge clk);
        vectors++;
        if (lat < 0 || !in_run) begin miscompares++; $display("FAIL rst_mid_setup: got lat=%0d run=%b want RUN reached", lat, in_run); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (outs() !== 87'd0) begin miscompares++; $display("FAIL rst_mid_outputs: got %h want 0", outs()); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rd_valid || bus.rd_gnt || bus.wr_gnt || bus.wr_done) pulses++;
        end
        vectors++;
        if (pulses != 0 || bus.arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_quiet: got pulses=%0d busy=%b want 0 0", pulses, bus.arb_busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h1000 + 16'(i);
        ref_mem[12'h123] = 16'hBEEF;
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_refresh();
        test_back_to_back();
        vectors++;
        if (m_both != 0) begin miscompares++; $display("FAIL both_enables: got %0d cycles want 0", m_both); end
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
